// File: rtl/ram_arbiter_if.sv
// Bundle of fetch, load/store and single-port RAM signals around ram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_arbiter_if #(
  parameter int unsigned AW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_byte_we;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;
  logic          ls_err;

  logic          ram_cs;
  logic          ram_we;
  logic          ram_re;
  logic [3:0]    ram_byte_we;
  logic [31:0]   ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_byte_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output ram_cs, ram_we, ram_re, ram_byte_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_byte_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  ram_cs, ram_we, ram_re, ram_byte_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port RAM.
// LS wins by default; IF is promoted after STARVE_MAX consecutive denials.
module ram_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input logic           clk,
  input logic           rst,
  ram_arbiter_if.slave  bus
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {TagNone, TagIf, TagLs} tag_e;

  tag_e          tag_q, tag_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic [31:0]   if_hold_q, ls_hold_q;
  logic          promote, if_gnt, ls_gnt, byte_we_ok;
  logic [AW-1:0] if_word, ls_word;

  assign if_word = bus.if_addr >> 2;
  assign ls_word = bus.ls_addr >> 2;

  always_comb begin
    byte_we_ok = 1'b0;
    case (bus.ls_byte_we)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: byte_we_ok = 1'b1;
      default: byte_we_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q     <= TagNone;
      starve_q  <= '0;
      err_q     <= 1'b0;
      if_hold_q <= '0;
      ls_hold_q <= '0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      if (bus.if_rvalid) if_hold_q <= bus.ram_rdata;
      if (bus.ls_rvalid) ls_hold_q <= bus.ram_rdata;
    end
  end

  // Everything combinational is gated by rst so reset clears outputs without waiting for an edge.
  always_comb begin
    promote         = 1'b0;
    ls_gnt          = 1'b0;
    if_gnt          = 1'b0;
    tag_d           = TagNone;
    starve_d        = '0;
    err_d           = 1'b0;
    bus.ram_cs      = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_re      = 1'b0;
    bus.ram_byte_we = 4'b0000;
    bus.ram_addr    = '0;
    bus.ram_wdata   = '0;
    if (rst) begin
      promote = bus.if_req && (starve_q == CW'(STARVE_MAX));
      ls_gnt  = bus.ls_req && !promote;
      if_gnt  = bus.if_req && !ls_gnt;
      if (if_gnt) begin
        bus.ram_cs   = 1'b1;
        bus.ram_re   = 1'b1;
        bus.ram_addr = 32'(if_word);
        tag_d        = TagIf;
      end else if (ls_gnt && !bus.ls_we) begin
        bus.ram_cs   = 1'b1;
        bus.ram_re   = 1'b1;
        bus.ram_addr = 32'(ls_word);
        tag_d        = TagLs;
      end else if (ls_gnt && byte_we_ok) begin
        bus.ram_cs      = 1'b1;
        bus.ram_we      = 1'b1;
        bus.ram_byte_we = bus.ls_byte_we;
        bus.ram_addr    = 32'(ls_word);
        bus.ram_wdata   = bus.ls_wdata;
      end else if (ls_gnt) begin
        // Illegal write: accepted but dropped, reported next cycle.
        err_d = 1'b1;
      end
      if (bus.if_req && !if_gnt) begin
        starve_d = (starve_q == CW'(STARVE_MAX)) ? starve_q : starve_q + CW'(1);
      end
    end
  end

  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.ls_gnt    = ls_gnt;
    // A flush in the response cycle swallows the fetch data.
    bus.if_rvalid = (tag_q == TagIf) && !bus.if_flush;
    bus.ls_rvalid = (tag_q == TagLs);
    bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : if_hold_q;
    bus.ls_rdata  = bus.ls_rvalid ? bus.ram_rdata : ls_hold_q;
    bus.ls_err    = err_q;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a cycle-level reference model.
module tb_ram_arbiter;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned AW         = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW)) bus ();

  ram_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .AW        (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: who owns the response due next cycle, starvation run, pending error.
  int          starve   = 0;
  int          owner    = 0;  // 0 none, 1 fetch, 2 load
  bit          err_pend = 1'b0;
  logic [31:0] if_hold  = '0;
  logic [31:0] ls_hold  = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit legal_bwe(input logic [3:0] b);
    return b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  task automatic set_in(input bit ir, input logic [31:0] ia, input bit fl, input bit lr,
                        input bit lwe, input logic [3:0] bwe, input logic [31:0] la,
                        input logic [31:0] wd);
    bus.if_req     = ir;
    bus.if_addr    = ia;
    bus.if_flush   = fl;
    bus.ls_req     = lr;
    bus.ls_we      = lwe;
    bus.ls_byte_we = bwe;
    bus.ls_addr    = la;
    bus.ls_wdata   = wd;
    bus.ram_rdata  = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_if_gnt"}, 64'(bus.if_gnt), 64'd0);
    check_val({tag, "_ls_gnt"}, 64'(bus.ls_gnt), 64'd0);
    check_val({tag, "_if_rvalid"}, 64'(bus.if_rvalid), 64'd0);
    check_val({tag, "_ls_rvalid"}, 64'(bus.ls_rvalid), 64'd0);
    check_val({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
    check_val({tag, "_ls_rdata"}, 64'(bus.ls_rdata), 64'd0);
    check_val({tag, "_ls_err"}, 64'(bus.ls_err), 64'd0);
    check_val({tag, "_ram"}, {bus.ram_cs, bus.ram_we, bus.ram_re, bus.ram_byte_we,
                              bus.ram_addr, 25'd0}, 64'd0);
    check_val({tag, "_ram_wdata"}, 64'(bus.ram_wdata), 64'd0);
  endtask

  // Inputs are already applied (just after a falling edge); check, then advance one cycle.
  task automatic cycle(input string tag, input bit rst_mid);
    bit          promote, e_if, e_ls, ill, e_ifv, e_lsv;
    bit          e_cs, e_we, e_re;
    logic [3:0]  e_bwe;
    logic [31:0] e_addr, e_wd;
    #1;
    promote = bus.if_req && (starve >= STARVE_MAX);
    e_ls    = bus.ls_req && !promote;
    e_if    = bus.if_req && !e_ls;
    ill     = 1'b0;
    {e_cs, e_we, e_re, e_bwe, e_addr, e_wd} = '0;
    if (e_if) begin
      e_cs = 1; e_re = 1; e_addr = bus.if_addr >> 2;
    end else if (e_ls && !bus.ls_we) begin
      e_cs = 1; e_re = 1; e_addr = bus.ls_addr >> 2;
    end else if (e_ls && legal_bwe(bus.ls_byte_we)) begin
      e_cs = 1; e_we = 1; e_bwe = bus.ls_byte_we; e_addr = bus.ls_addr >> 2; e_wd = bus.ls_wdata;
    end else if (e_ls) begin
      ill = 1;
    end
    e_ifv = (owner == 1) && !bus.if_flush;
    e_lsv = (owner == 2);
    check_val({tag, "_if_gnt"}, 64'(bus.if_gnt), 64'(e_if));
    check_val({tag, "_ls_gnt"}, 64'(bus.ls_gnt), 64'(e_ls));
    if (ill) begin
      check_val({tag, "_ill_cs_we"}, 64'({bus.ram_cs, bus.ram_we}), 64'd0);
    end else begin
      check_val({tag, "_ram_ctl"}, 64'({bus.ram_cs, bus.ram_we, bus.ram_re, bus.ram_byte_we}),
                64'({e_cs, e_we, e_re, e_bwe}));
      check_val({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'(e_addr));
      check_val({tag, "_ram_wdata"}, 64'(bus.ram_wdata), 64'(e_wd));
    end
    check_val({tag, "_if_rvalid"}, 64'(bus.if_rvalid), 64'(e_ifv));
    check_val({tag, "_ls_rvalid"}, 64'(bus.ls_rvalid), 64'(e_lsv));
    check_val({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'(e_ifv ? bus.ram_rdata : if_hold));
    check_val({tag, "_ls_rdata"}, 64'(bus.ls_rdata), 64'(e_lsv ? bus.ram_rdata : ls_hold));
    check_val({tag, "_ls_err"}, 64'(bus.ls_err), 64'(err_pend));
    if (rst_mid) begin
      #1 rst = 1'b0;
      #1 check_all_zero({tag, "_in_reset"});
      starve = 0; owner = 0; err_pend = 0; if_hold = '0; ls_hold = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    @(posedge clk);
    if (e_ifv) if_hold = bus.ram_rdata;
    if (e_lsv) ls_hold = bus.ram_rdata;
    owner    = e_if ? 1 : ((e_ls && !bus.ls_we) ? 2 : 0);
    err_pend = ill;
    starve   = (bus.if_req && !e_if) ? ((starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1) : 0;
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    set_in(0, 0, 0, 0, 0, 4'b0000, 0, 0);
    cycle(tag, 1'b0);
  endtask

  logic [3:0] bwe_pool [10];

  initial begin
    bwe_pool = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111,
                 4'b0101, 4'b0000, 4'b0111};

    // Requests present during reset must not be granted.
    set_in(1, 32'h40, 0, 1, 0, 4'b0000, 32'h80, 0);
    #3 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, then its response.
    set_in(1, 32'h10, 0, 0, 0, 4'b0000, 0, 0);
    cycle("fetch", 1'b0);
    idle("fetch_resp");

    // Contention: LS reads win four times, then the starved fetch goes through.
    for (int i = 0; i < 7; i++) begin
      set_in(1, 32'h100 + 32'(i * 4), 0, 1, 0, 4'b0000, 32'h200 + 32'(i * 4), 0);
      cycle($sformatf("contend%0d", i), 1'b0);
    end
    idle("contend_tail");

    // Byte store, then illegal store.
    set_in(0, 0, 0, 1, 1, 4'b0100, 32'h8, 32'hAB);
    cycle("byte_store", 1'b0);
    set_in(0, 0, 0, 1, 1, 4'b0101, 32'hC, 32'h55);
    cycle("ill_store", 1'b0);
    idle("ill_err");
    idle("ill_err_clear");
    set_in(0, 0, 0, 1, 1, 4'b0000, 32'h4, 32'h1);
    cycle("zero_bwe", 1'b0);
    idle("zero_bwe_err");

    // Flush in the response cycle, and flush with a new fetch in the same cycle.
    set_in(1, 32'h20, 0, 0, 0, 4'b0000, 0, 0);
    cycle("flush_grant", 1'b0);
    set_in(0, 0, 1, 0, 0, 4'b0000, 0, 0);
    cycle("flush_resp", 1'b0);
    set_in(1, 32'h24, 0, 0, 0, 4'b0000, 0, 0);
    cycle("flush2_grant", 1'b0);
    set_in(1, 32'h28, 1, 0, 0, 4'b0000, 0, 0);
    cycle("flush2_refetch", 1'b0);
    idle("flush2_resp");

    // Reset during an LS read grant, then grant right after release.
    set_in(0, 0, 0, 1, 0, 4'b0000, 32'h30, 0);
    cycle("rst_mid", 1'b1);
    idle("after_rst_idle");
    set_in(0, 0, 0, 1, 0, 4'b0000, 32'h34, 0);
    cycle("after_rst_grant", 1'b0);
    idle("after_rst_resp");

    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
             bwe_pool[$urandom_range(0, 9)], $urandom, $urandom);
      cycle("rand", 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive IF denials before IF is promoted.
REQ-002 SHALL have parameter AW, default 32: byte-address width.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch read request.
REQ-006 SHALL have port if_addr, input, AW: fetch byte address.
REQ-007 SHALL have port if_flush, input, 1: cancels any pending fetch response.
REQ-008 SHALL have ports if_gnt (output, 1), if_rvalid (output, 1) and if_rdata (output, 32): accept, response valid and fetch data.
REQ-009 SHALL have ports ls_req (input, 1), ls_we (input, 1), ls_byte_we (input, 4), ls_addr (input, AW) and ls_wdata (input, 32): load/store request.
REQ-010 SHALL have ports ls_gnt (output, 1), ls_rvalid (output, 1), ls_rdata (output, 32) and ls_err (output, 1): accept, load valid, load data and write-error pulse.
REQ-011 SHALL have ports ram_cs, ram_we and ram_re (outputs, 1 each), ram_byte_we (output, 4), ram_addr and ram_wdata (outputs, 32): single-port RAM command.
REQ-012 SHALL have port ram_rdata, input, 32: RAM read data, registered, 1-cycle latency.

Function
REQ-013 SHALL accept a transaction when req and gnt are both high in the same cycle; gnt SHALL be combinational from req and internal state.
REQ-014 SHALL grant at most one requester per cycle.
REQ-015 SHALL give ls priority by default.
REQ-016 SHALL keep a starve counter: +1 each cycle if_req=1 and if_gnt=0, saturating at STARVE_MAX; cleared when IF is granted or when if_req=0.
REQ-017 SHALL grant IF over LS when the counter equals STARVE_MAX.
REQ-018 SHALL drive ram_cs=1 in the grant cycle, with ram_addr = {2'b0, addr[AW-1:2]} (word index); ram_addr SHALL be 0 when idle.
REQ-019 SHALL, for an IF grant or an LS read, drive ram_re=1 and ram_we=0.
REQ-020 SHALL, for an LS write, drive ram_we=1 with ram_byte_we=ls_byte_we and ram_wdata=ls_wdata.
REQ-021 SHALL treat only these ls_byte_we values as legal: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-022 SHALL still grant an LS write whose byte_we is illegal, but SHALL keep ram_cs=0 and ram_we=0 and pulse ls_err for one cycle in the next cycle.
REQ-023 SHALL hold a response tag register with values NONE, IF and LS, loaded in the grant cycle.
REQ-024 SHALL, in the next cycle, assert the rvalid of the tagged owner for exactly 1 cycle, with rdata = ram_rdata.
REQ-025 SHALL read-latency = 1 cycle from grant; back-to-back grants every cycle SHALL be sustained.
REQ-026 SHALL hold if_rdata and ls_rdata at their last value when the matching rvalid=0.
REQ-027 SHALL, when if_flush=1, clear an IF tag so no if_rvalid follows.
REQ-028 SHALL, when if_flush=1 and if_req=1 in the same cycle, still grant the new fetch and deliver it normally.
REQ-029 SHALL treat an LS write with ls_we=1 and ls_byte_we=0000 as illegal (ls_err).
REQ-030 SHALL, with no requests, drive all RAM outputs to 0.

Reset
REQ-031 SHALL, while rst=0, force these to 0 asynchronously: if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err, every ram_* output, the starve counter and the tag (tag=NONE).
REQ-032 SHALL, when reset is asserted mid-transaction, drop the pending response; no rvalid follows deassertion.
REQ-033 SHALL, in the first cycle after reset release, grant normally.

Verification
REQ-034 Single fetch: if_req=1 with if_addr=0x10 -> if_gnt=1, ram_addr=4, ram_re=1; next cycle if_rvalid=1 with if_rdata=ram_rdata.
REQ-035 Contention: if_req and ls_req held high, ls reads -> LS granted for 4 cycles, IF granted on the 5th, counter then 0.
REQ-036 Byte store: ls_we=1, byte_we=0100, addr=0x8, wdata=0xAB -> ram_we=1, ram_addr=2, ram_byte_we=0100, no rvalid, ls_err=0.
REQ-037 Illegal store: byte_we=0101 -> ls_gnt=1, ram_cs=0, ls_err=1 next cycle only.
REQ-038 Flush: IF granted at cycle N and if_flush=1 at N+1 without if_req -> if_rvalid=0 at N+1.
REQ-039 Reset mid-read: LS read granted, then rst=0 before the next edge -> ls_rvalid stays 0 and all outputs stay 0 until the first new grant.
